rdyack_rr_arbiter: RTL
======================

Name: rdyack_rr_arbiter

Overview:
- Shares one rdy/ack destination among N rdy/ack requesters using round-robin priority.
- Once a requester is granted, the grant stays on it until its transaction completes (single beat, or whole packet when PACKET=1).
- Sits in front of a shared datapath resource (memory port, serializer, shared bus).
- The consumer muxes payload with dst_sel; the block never touches data.

Parameters:
- N, 4, number of requesters; legal range 2..32.
- PACKET, 1, 1 = hold grant until a beat with src_lasts[sel]=1 is acked; 0 = release after every acked beat.
- _C_N, $clog2(N), width of dst_sel; derived, never overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- src_rdys  input  N  per-requester ready; once raised, held until the matching ack.
- src_acks  output  N  per-requester ack; one-hot or zero.
- src_lasts  input  N  per-requester last-beat flag; sampled only while that requester is granted.
- dst_rdy  output  1  ready toward the shared resource.
- dst_ack  input  1  ack from the shared resource.
- dst_last  output  1  src_lasts[dst_sel] when PACKET=1, constant 1 when PACKET=0.
- dst_sel  output  _C_N  index of the requester currently presented.
- busy  output  1  high while the grant is locked (LOCKED state).

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - state←IDLE, ptr←0, lock_sel←0.
  - Outputs while in reset: dst_rdy=0, src_acks=0, busy=0, dst_sel=0.
  - A mid-transaction reset drops the lock with no ack issued. Requesters must tolerate re-arbitration.
- State IDLE:
  - cand = first set bit of src_rdys, searching from ptr upward and wrapping (ptr, ptr+1, …, N-1, 0, …).
  - dst_sel=cand, combinationally, zero latency; dst_rdy=|src_rdys.
  - If no request: dst_sel=ptr, dst_rdy=0.
- State LOCKED:
  - dst_sel=lock_sel; dst_rdy=src_rdys[lock_sel].
  - Other requests are ignored, no matter their priority.
- Ack routing: src_acks = dst_ack ? (1<<dst_sel) : 0. dst_ack while dst_rdy=0 is a protocol error (flagged by an assertion).
- done = dst_ack && dst_last.
- Transitions on a clk edge:
  - IDLE, dst_rdy && done: stay IDLE; ptr←(dst_sel+1) mod N.
  - IDLE, dst_rdy && !done (unacked beat, or acked non-last beat): →LOCKED; lock_sel←dst_sel.
  - LOCKED, done: →IDLE; ptr←(lock_sel+1) mod N.
  - Otherwise: hold state.
- Wrap: ptr increments modulo N; for non-power-of-2 N, N-1 goes to 0.
- Simultaneous events:
  - Completion and a new request from another requester in the same cycle: the new request is arbitrated next cycle with the updated ptr. There are no bubbles beyond that one edge.
  - Back-to-back requests from the same requester are allowed, but it drops to lowest priority after each completion.
- Fairness: any requester holding rdy is granted within N-1 completed transactions (packets when PACKET=1).
- PACKET=0: LOCKED is entered only for an unacked beat and exits on its ack.

Decomposition:
- Shared package rdyack_pkg: `p_C-style width constants and the state enum typedef {IDLE, LOCKED}.
- Natural sub-module: rr_pick, combinational. Inputs req[N] and ptr; outputs idx and any. Implemented as a double-width mask-and-priority-encode. It is reusable by other schedulers.

Test Plan:
- Single requester: N=4, src_rdys=4'b0100 at cycle 1, dst_ack at cycle 3, last=1 → dst_sel=2 during cycles 1–3; src_acks=4'b0100 at cycle 3 only; ptr=3 afterwards.
- Round-robin: all four rdy held continuously, PACKET=0, dst_ack tied to dst_rdy → grant order 0,1,2,3,0 on consecutive cycles; each src_ack is one cycle wide.
- Packet lock: PACKET=1, req0 sends 3 beats (last on the 3rd), req1 rdy throughout → dst_sel=0 for all 3 acks, busy=1 between them; dst_sel=1 on the cycle after the last ack.
- Wrap, non-power-of-2: N=3, ptr=2, src_rdys=3'b011 → dst_sel=0; after completion ptr=1 and next grant=1.
- Reset mid-packet: lock on req2 after 1 of 4 beats, rst=1 for one cycle → dst_rdy=0 and src_acks=0 during reset; then IDLE with ptr=0, and req0 wins over req2 if both are ready.
- Rdy without ack: req1 rdy, dst_ack=0 for 10 cycles while req0 raises rdy → dst_sel stays 1, busy=1, src_acks=0 throughout.

Source files
------------

// File: rtl/rdyack_pkg.sv
// Shared definitions for the rdy/ack round-robin arbiter slice.
// Holds the FSM state constants, a matching enum typedef for code that
// prefers a named type, and a width helper that keeps index ports at
// least one bit wide.
package rdyack_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    typedef enum logic [0:0] {
        IDLE   = ST_IDLE,
        LOCKED = ST_LOCKED
    } state_t;

    // Width of an index into n requesters.
    function automatic int p_c_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Finds the first set bit of req, starting the search at ptr and wrapping
// around to bit 0. It is reusable by any scheduler that keeps its own
// rotating pointer.
// Ports:
//   req - request vector, one bit per requester
//   ptr - index that currently has the highest priority
//   idx - chosen index; equals ptr when nothing is requesting
//   any - high when at least one request bit is set
module rr_pick
    import rdyack_pkg::*;
#(
    parameter int N = 4,
    localparam int W = p_c_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    localparam logic [2*N-1:0] ONE = {{(2*N-1){1'b0}}, 1'b1};

    logic [2*N-1:0] keep;
    logic [2*N-1:0] dbl;

    // The request vector is doubled so that the wrapped search becomes a
    // plain lowest-set-bit search. Bits below ptr in the lower copy are
    // masked off; the upper copy supplies the wrapped-around candidates.
    always_comb begin
        keep = ~((ONE << ptr) - ONE);
        dbl  = {req, req} & keep;
        any  = |req;
        idx  = ptr;
        // Descending scan so the lowest set position is the one that sticks.
        for (int i = 2*N-1; i >= 0; i--) begin
            if (dbl[i]) begin
                idx = (i >= N) ? W'(i - N) : W'(i);
            end
        end
    end

endmodule

// File: rtl/rdyack_rr_arbiter.sv
// Round-robin arbiter sharing one rdy/ack destination among N requesters.
// A granted requester keeps the grant until its transaction completes:
// one acked beat when PACKET=0, or an acked beat flagged last when
// PACKET=1. The consumer muxes payload with dst_sel; no data passes here.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   src_rdys  - per-requester ready, held until acked
//   src_acks  - per-requester ack, one-hot or zero
//   src_lasts - per-requester last-beat flag
//   dst_rdy   - ready toward the shared resource
//   dst_ack   - ack from the shared resource
//   dst_last  - last flag of the presented requester (1 when PACKET=0)
//   dst_sel   - index of the presented requester
//   busy      - high while the grant is locked on one requester
module rdyack_rr_arbiter
    import rdyack_pkg::*;
#(
    parameter int N      = 4,
    parameter bit PACKET = 1'b1,
    localparam int _C_N  = p_c_width(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    src_rdys,
    output logic [N-1:0]    src_acks,
    input  logic [N-1:0]    src_lasts,
    output logic            dst_rdy,
    input  logic            dst_ack,
    output logic            dst_last,
    output logic [_C_N-1:0] dst_sel,
    output logic            busy
);

    logic [0:0]      state;
    logic [_C_N-1:0] ptr;
    logic [_C_N-1:0] lock_sel;
    logic [_C_N-1:0] pick_idx;
    logic            pick_any;
    logic            done;

    function automatic logic [_C_N-1:0] next_idx(input logic [_C_N-1:0] i);
        return (int'(i) == N - 1) ? '0 : i + 1'b1;
    endfunction

    rr_pick #(
        .N (N)
    ) u_pick (
        .req (src_rdys),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Presentation toward the shared resource. While idle the picker result
    // is passed straight through so a lone request sees no latency; once
    // locked only the owner is looked at. Reset forces everything quiet.
    always_comb begin
        dst_sel = '0;
        dst_rdy = 1'b0;
        busy    = 1'b0;
        if (!rst) begin
            if (state == ST_LOCKED) begin
                dst_sel = lock_sel;
                dst_rdy = src_rdys[lock_sel];
                busy    = 1'b1;
            end else begin
                dst_sel = pick_idx;
                dst_rdy = pick_any;
            end
        end
    end

    // The destination ack is steered back to whichever requester is shown.
    always_comb begin
        src_acks = '0;
        if (!rst && dst_ack) begin
            src_acks[dst_sel] = 1'b1;
        end
    end

    assign dst_last = PACKET ? src_lasts[dst_sel] : 1'b1;
    assign done     = dst_ack && dst_last;

    // Grant FSM. A completed transaction moves the pointer just past the
    // winner so it drops to lowest priority; anything that does not finish
    // in the cycle it is first presented locks the grant on that requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            lock_sel <= '0;
        end else if (state == ST_IDLE) begin
            if (dst_rdy) begin
                if (done) begin
                    ptr <= next_idx(dst_sel);
                end else begin
                    state    <= ST_LOCKED;
                    lock_sel <= dst_sel;
                end
            end
        end else begin
            if (done) begin
                state <= ST_IDLE;
                ptr   <= next_idx(lock_sel);
            end
        end
    end

    // The resource must never ack a beat that was not offered.
    dst_ack_needs_rdy: assert property (@(posedge clk) disable iff (rst) dst_ack |-> dst_rdy);

endmodule
